regfile_sequencer: RTL
======================

# regfile_sequencer

Command-driven initiator for the 4-entry, 16-bit register file. Accepts single-register commands (LOAD, ADD, MOVE, READ) over a valid/ready interface. Sequences them onto the register file's single combinational read port and single synchronous write port. Returns READ results over a valid/ready response channel. Sits between a test/host controller and the register file, and is the only agent driving the register file's ports.

## Interface

Parameters:
- DATA_WIDTH, 16, register and immediate width
- INDEX_WIDTH, 2, register index width (2^INDEX_WIDTH registers)

Ports:
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  asynchronous, active-low: reset==0 resets immediately, release is sampled on clk
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  0 LOAD, 1 ADD, 2 MOVE, 3 READ
- cmd_dst  in  INDEX_WIDTH  destination register
- cmd_src  in  INDEX_WIDTH  source register
- cmd_imm  in  DATA_WIDTH  immediate for LOAD
- resp_valid  out  1  READ result present
- resp_ready  in  1  consumer takes result
- resp_data  out  DATA_WIDTH  READ result
- rf_read_index  out  INDEX_WIDTH  to register file read index
- rf_read_data  in  DATA_WIDTH  from register file read data; combinational in rf_read_index
- rf_write_index  out  INDEX_WIDTH  to register file write index
- rf_write_enable  out  1  to register file write enable
- rf_write_data  out  DATA_WIDTH  to register file write data

## Operation

- States: IDLE, RD_SRC, RD_DST, WRITE, RESP.
- cmd_ready = (state==IDLE). A command is accepted on a rising edge with cmd_valid && cmd_ready. At acceptance, op/dst/src/imm are latched.
- LOAD: IDLE -> WRITE. Write imm to dst.
- MOVE: IDLE -> RD_SRC -> WRITE. Capture rf_read_data in opnd_a; write opnd_a to dst.
- ADD: IDLE -> RD_SRC -> RD_DST -> WRITE. Capture src in opnd_a and dst in opnd_b; write opnd_a+opnd_b to dst.
- READ: IDLE -> RD_SRC -> RESP. The captured value is held in resp_data.
- RESP holds resp_valid=1 with stable resp_data until resp_ready is high at a rising edge, then returns to IDLE.
- WRITE always returns to IDLE after one cycle.
- rf_read_index = src in RD_SRC, dst in RD_DST, 0 otherwise.
- rf_write_enable = 1 only in WRITE. rf_write_index and rf_write_data are 0 outside WRITE.
- Arithmetic: the ADD result is truncated to DATA_WIDTH, i.e. wraps modulo 2^16 (default build).
- src==dst for ADD: the register is read twice, so the result is 2×value.
- No hazards: a write completes at the end of WRITE, and the next command's first read is at least 2 cycles later.
- reset asserted mid-command: the command is abandoned with no write and no response; state returns to IDLE.
- Reset values: cmd_ready=0 while reset==0, then 1 in IDLE after release. resp_valid=0, resp_data=0, rf_read_index=0, rf_write_index=0, rf_write_enable=0, rf_write_data=0, opnd_a=opnd_b=0.

## Timing

- LOAD: write enable high in cycle N+1 after acceptance at edge N; register updated at edge N+2. Command-to-command interval 2 cycles.
- MOVE: 3 cycles. ADD: 4 cycles.
- READ: resp_valid rises 2 cycles after acceptance (edge N+2). Minimum command-to-command interval is 3 cycles, plus any resp_ready stall.
- Operand capture happens at the rising edge that ends RD_SRC/RD_DST.
- cmd_* inputs are don't-care outside the acceptance edge.

## Configuration

- REGFILE_SEQ_SATURATE_EN defined: ADD saturates. If the 17-bit sum exceeds 2^DATA_WIDTH−1, the written value is all-ones (16'hFFFF).
- Undefined: ADD wraps modulo 2^DATA_WIDTH.
- No other behaviour differs between the two builds.

## Structure

- Package regfile_seq_pkg holds:
  - op_t enum: OP_LOAD=0, OP_ADD=1, OP_MOVE=2, OP_READ=3
  - state_t enum: IDLE, RD_SRC, RD_DST, WRITE, RESP
  - default width localparams
- Sub-module regfile_seq_alu: combinational, selects the write data (imm / opnd_a / opnd_a+opnd_b) and contains the REGFILE_SEQ_SATURATE_EN logic.
- The top level holds the FSM and the latched command fields.

## Test plan

- Reset: hold reset=0 for 3 cycles, release -> all outputs 0 during reset, cmd_ready=1 the cycle after release.
- LOAD then READ: LOAD r2=16'h1234, then READ src=r2 with resp_ready=1 -> resp_data=16'h1234, resp_valid high 2 cycles after READ acceptance. rf_write_enable high exactly 1 cycle with index 2.
- ADD wrap: LOAD r0=16'hFFF0, LOAD r1=16'h0020, ADD dst=r1 src=r0, READ r1:
  - default build -> 16'h0010
  - REGFILE_SEQ_SATURATE_EN build -> 16'hFFFF
- MOVE and src==dst ADD: LOAD r3=16'h0005, MOVE r0<-r3, ADD r0+=r0, READ r0 -> 16'h000A.
- Response backpressure: READ with resp_ready=0 for 5 cycles -> resp_valid held, resp_data stable, cmd_ready=0. resp_ready=1 -> returns to IDLE next cycle.
- Reset mid-ADD: assert reset in RD_DST -> no write pulse; a subsequent READ of dst returns the register file's reset value 0, since both blocks share reset.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// rtl/regfile_seq_pkg.sv - shared types and default widths for the register file sequencer
package regfile_seq_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int INDEX_WIDTH_DEF = 2;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_ADD  = 2'd1,
        OP_MOVE = 2'd2,
        OP_READ = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_SRC = 3'd1,
        RD_DST = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_seq_alu.sv
// rtl/regfile_seq_alu.sv - write-data select for the sequencer
// REGFILE_SEQ_SATURATE_EN: ADD clamps to all-ones on overflow instead of wrapping.
module regfile_seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  op_t                   op,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [DATA_WIDTH-1:0] opnd_a,
    input  logic [DATA_WIDTH-1:0] opnd_b,
    output logic [DATA_WIDTH-1:0] result
);

`ifdef REGFILE_SEQ_SATURATE_EN
    logic [DATA_WIDTH:0] sum;
    assign sum = {1'b0, opnd_a} + {1'b0, opnd_b};
`endif

    always_comb begin
        result = '0;
        case (op)
            OP_LOAD: result = imm;
            OP_MOVE: result = opnd_a;
`ifdef REGFILE_SEQ_SATURATE_EN
            OP_ADD:  result = sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
`else
            OP_ADD:  result = opnd_a + opnd_b;
`endif
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - command sequencer driving a 1R/1W register file
// REGFILE_SEQ_SATURATE_EN (see regfile_seq_alu) selects saturating ADD.
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int INDEX_WIDTH = INDEX_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [INDEX_WIDTH-1:0] cmd_dst,
    input  logic [INDEX_WIDTH-1:0] cmd_src,
    input  logic [DATA_WIDTH-1:0]  cmd_imm,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_WIDTH-1:0]  resp_data,
    output logic [INDEX_WIDTH-1:0] rf_read_index,
    input  logic [DATA_WIDTH-1:0]  rf_read_data,
    output logic [INDEX_WIDTH-1:0] rf_write_index,
    output logic                   rf_write_enable,
    output logic [DATA_WIDTH-1:0]  rf_write_data
);

    state_t                 state, state_next;
    op_t                    op_q;
    logic [INDEX_WIDTH-1:0] dst_q, src_q;
    logic [DATA_WIDTH-1:0]  imm_q, opnd_a, opnd_b, alu_result;
    logic                   accept;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) begin
                state_next = (op_t'(cmd_op) == OP_LOAD) ? WRITE : RD_SRC;
            end
            RD_SRC: case (op_q)
                OP_ADD:  state_next = RD_DST;
                OP_READ: state_next = RESP;
                default: state_next = WRITE;
            endcase
            RD_DST:  state_next = WRITE;
            WRITE:   state_next = IDLE;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are forced to zero outside their owning state so the register file sees clean idle ports.
    always_comb begin
        cmd_ready       = reset && (state == IDLE);
        resp_valid      = (state == RESP);
        resp_data       = (state == RESP) ? opnd_a : '0;
        rf_read_index   = '0;
        rf_write_enable = (state == WRITE);
        rf_write_index  = (state == WRITE) ? dst_q : '0;
        rf_write_data   = (state == WRITE) ? alu_result : '0;
        if (state == RD_SRC) rf_read_index = src_q;
        if (state == RD_DST) rf_read_index = dst_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= OP_LOAD;
            dst_q  <= '0;
            src_q  <= '0;
            imm_q  <= '0;
            opnd_a <= '0;
            opnd_b <= '0;
        end else begin
            if (accept) begin
                op_q  <= op_t'(cmd_op);
                dst_q <= cmd_dst;
                src_q <= cmd_src;
                imm_q <= cmd_imm;
            end
            if (state == RD_SRC) opnd_a <= rf_read_data;
            if (state == RD_DST) opnd_b <= rf_read_data;
        end
    end

    regfile_seq_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op     (op_q),
        .imm    (imm_q),
        .opnd_a (opnd_a),
        .opnd_b (opnd_b),
        .result (alu_result)
    );

endmodule
